// File: rtl/audio_mem_engine.sv
// audio_mem_engine: AC97 sample packer/unpacker for banked ZBT memory.
// Define AUDIO_MEM_SAT_EN to saturate the overdub mix instead of wrapping.
module audio_mem_engine #(
  parameter int SAMPLE_W  = 12,
  parameter int SPW       = 3,
  parameter int NUM_BANKS = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ready,
  input  logic [SAMPLE_W-1:0]               audio_in,
  input  logic                              start_song,
  input  logic [3:0]                        song_choice,
  input  logic [1:0]                        mode,
  input  logic                              pause_song,
  input  logic                              song_done,
  input  logic [NUM_BANKS*SAMPLE_W*SPW-1:0] mem_read,
  output logic [SAMPLE_W*SPW-1:0]           mem_write,
  output logic [NUM_BANKS-1:0]              we,
  output logic                              word_strobe,
  output logic [SAMPLE_W-1:0]               audio_out
);

  localparam int WORD_W = SAMPLE_W * SPW;
  localparam int BSEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int SLOT_W = (SPW > 1) ? $clog2(SPW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t              state, state_nx;
  logic [SLOT_W-1:0]   slot;
  logic [WORD_W-1:0]   pack, play_word;
  logic [1:0]          mode_q;
  logic [BSEL_W-1:0]   bank_q;

  logic                tick, last, bank_ok;
  logic                rec, dub;
  logic [WORD_W-1:0]   pb_shift, rd_word, word_nx;
  logic [SAMPLE_W-1:0] pb_s, mix, out_s, stored;
  logic [SAMPLE_W:0]   sum;
  logic                unused_sc;

  assign unused_sc = ^song_choice;

  assign tick = (state == RUN) && ready && !pause_song
              && !song_done && !start_song;
  assign last    = (slot == SLOT_W'(SPW - 1));
  assign bank_ok = (int'(bank_q) < NUM_BANKS);
  assign rec     = (mode_q == 2'b01);
  assign dub     = (mode_q == 2'b10);

  assign pb_shift = play_word << (int'(slot) * SAMPLE_W);
  assign pb_s     = pb_shift[WORD_W-1 -: SAMPLE_W];
  assign sum      = {pb_s[SAMPLE_W-1], pb_s}
                  + {audio_in[SAMPLE_W-1], audio_in};
  assign word_nx  = (pack << SAMPLE_W) | WORD_W'(stored);

  // Overdub mix: clamp on signed overflow when enabled, else wrap
  always_comb begin
`ifdef AUDIO_MEM_SAT_EN
    if (sum[SAMPLE_W] != sum[SAMPLE_W-1])
      mix = {sum[SAMPLE_W], {(SAMPLE_W-1){~sum[SAMPLE_W]}}};
    else
      mix = sum[SAMPLE_W-1:0];
`else
    mix = sum[SAMPLE_W-1:0];
`endif
  end

  // Select speaker sample and the sample to be stored for this tick
  always_comb begin
    out_s  = pb_s;
    stored = audio_in;
    unique case (1'b1)
      rec:     out_s = audio_in;
      dub: begin
        out_s  = mix;
        stored = mix;
      end
      default: out_s = pb_s;
    endcase
  end

  // Read word of the latched bank; out-of-range banks read as zero
  always_comb begin
    rd_word = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      if (bank_q == BSEL_W'(b))
        rd_word = mem_read[b*WORD_W +: WORD_W];
  end

  // Next state; a restart overrides everything else
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = IDLE;
      RUN: begin
        if (pause_song)     state_nx = PAUSED;
        else if (song_done) state_nx = DONE;
      end
      PAUSED:  if (!pause_song) state_nx = RUN;
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (start_song) state_nx = RUN;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Slot, packing, playback word and write/strobe pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      slot        <= '0;
      pack        <= '0;
      play_word   <= '0;
      mem_write   <= '0;
      we          <= '0;
      word_strobe <= 1'b0;
      audio_out   <= '0;
      mode_q      <= 2'b00;
      bank_q      <= '0;
    end else begin
      we          <= '0;
      word_strobe <= 1'b0;
      if (start_song) begin
        slot      <= '0;
        pack      <= '0;
        play_word <= '0;
        mode_q    <= mode;
        bank_q    <= song_choice[3 -: BSEL_W];
      end else if (tick) begin
        slot      <= last ? '0 : slot + 1'b1;
        audio_out <= bank_ok ? out_s : '0;
        if (rec || dub) pack <= word_nx;
        if (last) begin
          play_word   <= rd_word;
          word_strobe <= 1'b1;
          if (rec || dub) begin
            mem_write <= word_nx;
            if (bank_ok) we <= NUM_BANKS'(1) << bank_q;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_mem_engine.sv
// tb_audio_mem_engine: scoreboard bench for audio_mem_engine.
// Reference model follows AUDIO_MEM_SAT_EN like the design.
module tb_audio_mem_engine;

  localparam int SW = 12;
  localparam int SPW = 3;
  localparam int NB = 2;
  localparam int WW = SW * SPW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ready = 1'b0;
  logic [SW-1:0] audio_in = '0;
  logic          start_song = 1'b0;
  logic [3:0]    song_choice = '0;
  logic [1:0]    mode = '0;
  logic          pause_song = 1'b0;
  logic          song_done = 1'b0;
  logic [NB*WW-1:0] mem_read = '0;
  logic [WW-1:0] mem_write;
  logic [NB-1:0] we;
  logic          word_strobe;
  logic [SW-1:0] audio_out;

  audio_mem_engine #(.SAMPLE_W(SW), .SPW(SPW), .NUM_BANKS(NB)) dut (
    .clk(clk), .reset(reset), .ready(ready), .audio_in(audio_in),
    .start_song(start_song), .song_choice(song_choice), .mode(mode),
    .pause_song(pause_song), .song_done(song_done),
    .mem_read(mem_read), .mem_write(mem_write), .we(we),
    .word_strobe(word_strobe), .audio_out(audio_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] a;
    logic [NB-1:0] we;
    logic          ws;
    logic [WW-1:0] mw;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0 idle, 1 running, 2 paused, 3 finished
  int            m_st;
  logic [1:0]    m_mode;
  int            m_bank;
  logic [SW-1:0] m_play[$];
  logic [SW-1:0] m_rec[$];
  logic [SW-1:0] m_audio;
  logic [WW-1:0] m_mw;

  logic [1:0]    d_mode;
  logic [3:0]    d_sc;
  logic [NB*WW-1:0] d_mr;

  task automatic new_song();
    m_play.delete();
    for (int i = 0; i < SPW; i++) m_play.push_back('0);
    m_rec.delete();
  endtask

  task automatic cyc(input logic r, input logic st, input logic rd,
                     input logic ps, input logic sd,
                     input logic [SW-1:0] ain);
    exp_t e;
    logic [SW-1:0] pb, outv, stor;
    logic [WW-1:0] w;
    int pbi, aii, mx;
    @(negedge clk);
    reset = r; start_song = st; ready = rd;
    pause_song = ps; song_done = sd; audio_in = ain;
    mode = d_mode; song_choice = d_sc; mem_read = d_mr;
    e.we = '0;
    e.ws = 1'b0;
    if (r) begin
      m_st = 0; m_mode = 2'b00; m_bank = 0;
      new_song();
      m_audio = '0; m_mw = '0;
    end else if (st) begin
      m_st = 1; m_mode = d_mode; m_bank = int'(d_sc[3]);
      new_song();
    end else begin
      if (m_st == 1 && rd && !ps && !sd) begin
        pb = m_play.pop_front();
        pbi = $signed(pb);
        aii = $signed(ain);
        mx = pbi + aii;
`ifdef AUDIO_MEM_SAT_EN
        if (mx > 2047) mx = 2047;
        if (mx < -2048) mx = -2048;
`endif
        case (m_mode)
          2'b01: begin outv = ain; stor = ain; end
          2'b10: begin outv = mx[SW-1:0]; stor = mx[SW-1:0]; end
          default: begin outv = pb; stor = pb; end
        endcase
        m_audio = outv;
        if (m_mode == 2'b01 || m_mode == 2'b10) m_rec.push_back(stor);
        if (m_play.size() == 0) begin
          w = d_mr[m_bank*WW +: WW];
          for (int k = 0; k < SPW; k++)
            m_play.push_back(w[WW-1-k*SW -: SW]);
          e.ws = 1'b1;
          if (m_mode == 2'b01 || m_mode == 2'b10) begin
            w = '0;
            foreach (m_rec[i]) w = (w << SW) | WW'(m_rec[i]);
            m_mw = w;
            e.we = NB'(1) << m_bank;
            m_rec.delete();
          end
        end
      end
      if (m_st == 1) begin
        if (ps) m_st = 2;
        else if (sd) m_st = 3;
      end else if (m_st == 2 && !ps) begin
        m_st = 1;
      end
    end
    e.a = m_audio;
    e.mw = m_mw;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [WW-1:0] act,
                     input logic [WW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: one expectation per clock, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("audio_out", WW'(audio_out), WW'(e.a));
        chk("we", WW'(we), WW'(e.we));
        chk("word_strobe", WW'(word_strobe), WW'(e.ws));
        chk("mem_write", mem_write, e.mw);
      end
    end
  end

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic tk(input logic [SW-1:0] ain);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ain);
    idle();
  endtask

  task automatic start(input logic [1:0] md, input logic [3:0] sc);
    d_mode = md;
    d_sc = sc;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    logic p;
    d_mode = '0; d_sc = '0; d_mr = '0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    idle();

    // record into bank 1
    start(2'b01, 4'b1000);
    tk(12'h001); tk(12'h002); tk(12'h003);
    idle();

    // playback unpacking, MSB first
    d_mr = {36'h0, 36'hABC123456};
    start(2'b00, 4'b0000);
    tk('0); tk('0); tk('0);
    tk('0); tk('0); tk('0);

    // overdub overflow
    d_mr = {36'h0, 36'h7FF7FF7FF};
    start(2'b10, 4'b0000);
    tk('0); tk('0); tk('0);
    tk(12'h001); tk(12'h800); tk(12'h7FF);

    // pause mid-word
    start(2'b01, 4'b0000);
    tk(12'h111); tk(12'h222);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'hEEE);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    end
    idle();
    tk(12'h333);
    idle();

    // song_done with ready at slot 1, then restart
    start(2'b01, 4'b1000);
    tk(12'h0A1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h0A2);
    tk(12'h0A3); tk(12'h0A4); tk(12'h0A5);
    start(2'b01, 4'b1000);
    tk(12'h0B1); tk(12'h0B2); tk(12'h0B3);

    // bank 0 from song_choice 0100, then reset mid-word
    start(2'b01, 4'b0100);
    tk(12'h5A5); tk(12'h0F0); tk(12'h00F);
    tk(12'h123); tk(12'h456);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    idle();
    tk(12'h789);
    idle();

    // randomized traffic
    p = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(15, 0) == 0) p = ~p;
      d_mode = 2'($urandom);
      d_sc = 4'($urandom);
      d_mr = {8'($urandom), $urandom, $urandom};
      cyc(($urandom_range(299, 0) == 0),
          ($urandom_range(39, 0) == 0),
          ($urandom_range(2, 0) == 0),
          p,
          ($urandom_range(79, 0) == 0),
          12'($urandom));
    end

    idle();
    idle();
    @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/audio_mem_engine.md
AUDIO_MEM_ENGINE -- requirements
Module: audio_mem_engine

Interface
REQ-001 Parameter SAMPLE_W, default 12: audio sample width in bits.
REQ-002 Parameter SPW, default 3: samples packed per memory word; WORD_W = SAMPLE_W*SPW (36 by default).
REQ-003 Parameter NUM_BANKS, default 2: ZBT banks, range 1..4; BSEL_W = max(1, clog2(NUM_BANKS)).
REQ-004 clk  in  1  system clock.
REQ-005 reset  in  1  reset; synchronous, active-high.
REQ-006 ready  in  1  one-cycle pulse: new AC97 sample available.
REQ-007 audio_in  in  SAMPLE_W  signed sample from AC97.
REQ-008 start_song  in  1  restart pulse; latches mode and song_choice.
REQ-009 song_choice  in  4  song index; bank = song_choice[3 -: BSEL_W].
REQ-010 mode  in  2  00 playback, 01 record, 10 overdub, 11 reserved (treated as playback).
REQ-011 pause_song  in  1  level: freeze all state.
REQ-012 song_done  in  1  level from address calculator: end of song region.
REQ-013 mem_read  in  NUM_BANKS*WORD_W  read data; bank b occupies bits [b*WORD_W +: WORD_W].
REQ-014 mem_write  out  WORD_W  word to be written.
REQ-015 we  out  NUM_BANKS  per-bank write enable.
REQ-016 word_strobe  out  1  one-cycle pulse per completed word; advances the address calculator.
REQ-017 audio_out  out  SAMPLE_W  signed sample to speaker.

Function
REQ-018 FSM states IDLE, RUN, PAUSED, DONE; one state register.
REQ-019 IDLE->RUN on start_song; any state->RUN on start_song (restart has priority over every other input).
REQ-020 RUN->PAUSED when pause_song=1; PAUSED->RUN when pause_song=0; RUN->DONE when song_done=1; DONE leaves only on start_song or reset.
REQ-021 On start_song: slot<=0, pack register<=0, play word<=0, latched mode/bank<=inputs, we<=0; audio_out is not modified.
REQ-022 Only in RUN with ready=1 (a "tick"): slot advances 0..SPW-1 and wraps to 0.
REQ-023 Playback sample at slot k = play_word bits [WORD_W-1-k*SAMPLE_W -: SAMPLE_W] (MSB-first).
REQ-024 Playback mode tick: audio_out <= playback sample.
REQ-025 Record mode tick: audio_out <= audio_in; stored sample = audio_in.
REQ-026 Overdub mode tick: audio_out <= mix = playback sample + audio_in (signed, SAMPLE_W result per REQ-036); stored sample = mix.
REQ-027 Record/overdub tick: pack <= {pack[(SPW-1)*SAMPLE_W-1:0], stored sample}.
REQ-028 Tick with slot=SPW-1: play_word <= mem_read of the latched bank; next cycle word_strobe=1 for exactly one cycle in all modes.
REQ-029 Record/overdub tick with slot=SPW-1: mem_write <= full word including the current sample; next cycle we[bank]=1 for exactly one cycle, all other we bits 0.
REQ-030 we never asserts in playback mode, or in PAUSED, DONE or IDLE; partial words are never written.
REQ-031 Latched bank index >= NUM_BANKS: we stays 0 and audio_out is forced to 0 on ticks; word_strobe still pulses.
REQ-032 ready with song_done=1 in the same cycle: no tick; FSM enters DONE.
REQ-033 ready while PAUSED: ignored; slot and pack are held, so resuming continues mid-word.
REQ-034 Latency: audio_out updates 1 cycle after ready; we and word_strobe assert 1 cycle after the completing tick.

Reset
REQ-035 Reset: state=IDLE, slot=0, pack=0, play_word=0, mem_write=0, we=0, word_strobe=0, audio_out=0, latched mode=playback, latched bank=0; reset mid-word discards the partial word with no write.

Configuration
REQ-036 Macro AUDIO_MEM_SAT_EN defined: overdub mix saturates to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]; undefined: mix wraps modulo 2^SAMPLE_W.

Verification
REQ-037 Record, song_choice=4'b1000, samples 0x001,0x002,0x003 on ready -> mem_write=0x001002003, we=2'b10 for one cycle, word_strobe one pulse.
REQ-038 Playback, bank 0 mem_read=0xABC123456 latched at wrap -> next three ticks give audio_out 0xABC, 0x123, 0x456.
REQ-039 Overdub, playback 0x7FF plus audio_in 0x001 -> audio_out 0x7FF with AUDIO_MEM_SAT_EN, 0x800 without.
REQ-040 Record two samples, pause, 5 ready pulses, unpause, one sample -> exactly one write containing all three samples.
REQ-041 song_done with ready in the same cycle at slot 1 -> no write, state DONE; later start_song -> RUN, slot=0.
REQ-042 NUM_BANKS=2, song_choice=4'b0100 (BSEL_W=1, bank 0) record -> we=2'b01; reset asserted mid-word -> all outputs 0, no write.
